// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, FSM states,
// ALU operation codes and datapath mux select codes.
package mips_pkg;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BEQ    = 4'd8,
      S_IEXEC  = 4'd9,
      S_IWB    = 4'd10,
      S_JUMP   = 4'd11,
      S_JR     = 4'd12
   } state_t;

   // Also decoded by the ALU control block beside this controller.
   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } alu_op_t;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   localparam logic [1:0] PC_REG    = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       zero_ext;
      alu_op_t    alu_op;
      logic       alu_inst_sel;
      logic [1:0] pc_source;
      logic       retire;
      logic       illegal;
   } ctrl_t;

   // ANDI/ORI take their ALU function from the opcode and zero-extend the immediate.
   function automatic logic is_logic_imm(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI);
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller-to-datapath bundle: instruction/memory status in, every enable and
// mux select out.
interface multicycle_control_if;

   logic [5:0] opcode;
   logic       jr;
   logic       mem_ready;

   logic       pc_write;
   logic       branch;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       zero_ext;
   logic [1:0] alu_op;
   logic       alu_inst_sel;
   logic [1:0] pc_source;
   logic       retire;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  opcode, jr, mem_ready,
      output pc_write, branch, i_or_d, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, zero_ext,
             alu_op, alu_inst_sel, pc_source, retire, illegal, state
   );

   modport slave (
      output opcode, jr, mem_ready,
      input  pc_write, branch, i_or_d, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, zero_ext,
             alu_op, alu_inst_sel, pc_source, retire, illegal, state
   );

endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: steps each instruction
// through fetch/decode/execute/memory/writeback and drives all datapath controls.
module multicycle_control
   import mips_pkg::*;
#(
   parameter bit WAIT_STATES_OK = 1'b1
) (
   input logic                  clk,
   input logic                  rst_n,
   multicycle_control_if.master ctl
);

   state_t state_q, state_d;
   ctrl_t  c;
   logic   mem_rdy;
   logic   logic_imm;

   assign mem_rdy   = WAIT_STATES_OK ? ctl.mem_ready : 1'b1;
   assign logic_imm = is_logic_imm(ctl.opcode);

   // NOTE: non-blocking assignment so the register updates from pre-edge values only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output and the next state get a default first, so no branch infers a latch.
      state_d = state_q;
      c       = '0;
      case (state_q)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = SRCB_FOUR;
            c.alu_op    = ALU_ADD;
            c.pc_source = PC_ALU;
            c.ir_write  = mem_rdy;
            c.pc_write  = mem_rdy;
            if (mem_rdy) state_d = S_DECODE;
         end
         S_DECODE: begin
            c.alu_src_b = SRCB_IMM_SH2;
            case (ctl.opcode)
               OP_LW, OP_SW:             state_d = S_MEMADR;
               OP_R:                     state_d = S_EXEC;
               OP_BEQ:                   state_d = S_BEQ;
               OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
               OP_J:                     state_d = S_JUMP;
               default: begin
                  state_d   = S_FETCH;
                  c.illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            state_d     = (ctl.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
            if (mem_rdy) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.retire     = 1'b1;
            state_d      = S_FETCH;
         end
         S_MEMWR: begin
            c.i_or_d    = 1'b1;
            c.mem_write = 1'b1;
            c.retire    = mem_rdy;
            if (mem_rdy) state_d = S_FETCH;
         end
         S_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_B;
            c.alu_op    = ALU_FUNCT;
            state_d     = ctl.jr ? S_JR : S_RWB;
         end
         S_RWB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
            c.retire    = 1'b1;
            state_d     = S_FETCH;
         end
         S_BEQ: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = ALU_SUB;
            c.branch    = 1'b1;
            c.pc_source = PC_ALUOUT;
            c.retire    = 1'b1;
            state_d     = S_FETCH;
         end
         // IWB keeps the IEXEC selects so ALUOut stays valid while it is written back.
         S_IEXEC, S_IWB: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            if (logic_imm) begin
               c.alu_op       = ALU_FUNCT;
               c.alu_inst_sel = 1'b1;
               c.zero_ext     = 1'b1;
            end
            if (state_q == S_IEXEC) begin
               state_d = S_IWB;
            end else begin
               c.reg_write = 1'b1;
               c.retire    = 1'b1;
               state_d     = S_FETCH;
            end
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = PC_JUMP;
            c.retire    = 1'b1;
            state_d     = S_FETCH;
         end
         S_JR: begin
            c.pc_write  = 1'b1;
            c.pc_source = PC_REG;
            c.retire    = 1'b1;
            state_d     = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Strobes are gated by reset so nothing writes while rst_n is low.
   assign ctl.pc_write     = rst_n & c.pc_write;
   assign ctl.branch       = rst_n & c.branch;
   assign ctl.mem_write    = rst_n & c.mem_write;
   assign ctl.ir_write     = rst_n & c.ir_write;
   assign ctl.reg_write    = rst_n & c.reg_write;
   assign ctl.retire       = rst_n & c.retire;
   assign ctl.illegal      = rst_n & c.illegal;
   assign ctl.i_or_d       = c.i_or_d;
   assign ctl.mem_read     = c.mem_read;
   assign ctl.reg_dst      = c.reg_dst;
   assign ctl.mem_to_reg   = c.mem_to_reg;
   assign ctl.alu_src_a    = c.alu_src_a;
   assign ctl.alu_src_b    = c.alu_src_b;
   assign ctl.zero_ext     = c.zero_ext;
   assign ctl.alu_op       = c.alu_op;
   assign ctl.alu_inst_sel = c.alu_inst_sel;
   assign ctl.pc_source    = c.pc_source;
   assign ctl.state        = state_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback cycles, and drives every datapath enable and mux select. Supplies `alu_op` and the ALU-control input select to the existing ALU control decoder. Takes that decoder's `jr` flag back to steer register-jump instructions.

## Interface
- `WAIT_STATES_OK`, default 1: when 1, FETCH/MEMRD/MEMWR hold until `mem_ready`; when 0, `mem_ready` is ignored and treated as 1.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]; stable from DECODE onward.
- `jr` in 1: JR flag from the ALU control decoder; sampled in EXEC.
- `mem_ready` in 1: memory access completes this cycle.
- `pc_write` out 1: unconditional PC load.
- `branch` out 1: PC load if ALU zero.
- `i_or_d` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: instruction register load.
- `reg_dst` out 1: register destination; 1 = rd, 0 = rt.
- `mem_to_reg` out 1: writeback source; 1 = MDR, 0 = ALUOut.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 1: ALU A select; 0 = PC, 1 = A register.
- `alu_src_b` out 2: ALU B select; 00 = B, 01 = 4, 10 = extended imm, 11 = extended imm shifted left 2.
- `zero_ext` out 1: immediate extension; 1 = zero-extend, 0 = sign-extend.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = decode.
- `alu_inst_sel` out 1: ALU control `inst` source; 1 = opcode, 0 = funct.
- `pc_source` out 2: next-PC select; 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = A register.
- `retire` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal` out 1: one-cycle pulse in DECODE on an undefined opcode.
- `state` out 4: current state, for debug.

## Operation
- Opcodes:
  - R = 000000, LW = 100011, SW = 101011, BEQ = 000100
  - J = 000010, ADDI = 001000, ANDI = 001100, ORI = 001101
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BEQ 8, IEXEC 9, IWB 10, JUMP 11, JR 12. Codes 13–15 return to FETCH.
- Outputs are Moore decodes of `state`. The only exceptions are the `mem_ready` qualifications below. Any output not listed for a state is 0.
- **FETCH**
  - Drives `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write` and `pc_write` = `mem_ready`.
  - Transitions to DECODE when `mem_ready`; otherwise stays.
- **DECODE**
  - Drives `alu_src_b`=11, `alu_op`=00, computing the branch target.
  - Next state by opcode: LW/SW → MEMADR, R → EXEC, BEQ → BEQ, ADDI/ANDI/ORI → IEXEC, J → JUMP.
  - Any other opcode → FETCH with `illegal`=1.
- **MEMADR**: drives `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. LW → MEMRD, SW → MEMWR.
- **MEMRD**: drives `mem_read`=1, `i_or_d`=1. Goes to MEMWB on `mem_ready`.
- **MEMWB**: drives `reg_write`, `mem_to_reg`=1, `retire`. Returns to FETCH.
- **MEMWR**: drives `i_or_d`=1 and `mem_write`=1 throughout the state. `retire`=`mem_ready`; goes to FETCH on `mem_ready`.
- **EXEC**: drives `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Goes to JR if `jr`, else RWB.
- **RWB**: drives `reg_write`, `reg_dst`=1, `retire`. Returns to FETCH.
- **BEQ**: drives `alu_src_a`=1, `alu_op`=01, `branch`=1, `pc_source`=01, `retire`. Returns to FETCH.
- **IEXEC**
  - Drives `alu_src_a`=1, `alu_src_b`=10.
  - ADDI: `alu_op`=00.
  - ANDI/ORI: `alu_op`=10, `alu_inst_sel`=1, `zero_ext`=1.
  - Goes to IWB.
- **IWB**
  - Drives `reg_write`, `reg_dst`=0, `retire`.
  - Holds the IEXEC ALU selects, including `alu_inst_sel`/`zero_ext` for ANDI/ORI.
  - Returns to FETCH.
- **JUMP**: drives `pc_write`, `pc_source`=10, `retire`. Returns to FETCH.
- **JR**: drives `pc_write`, `pc_source`=11, `retire`. Returns to FETCH.

## Timing
- **Reset**
  - While `rst_n`=0: `state`=FETCH (0).
  - `pc_write`, `ir_write`, `reg_write`, `mem_write`, `branch`, `retire`, `illegal` are forced 0.
  - All other outputs take their FETCH values.
  - First fetch is the first edge after deassertion.
- **Mid-instruction reset**: abandons the instruction with no write strobe asserted afterwards. The interrupted instruction does not retire.
- **Zero-wait latencies in cycles**: R 4, LW 5, SW 4, BEQ 3, J 3, ADDI/ANDI/ORI 4, JR 4.
- **Wait states**: each low-`mem_ready` cycle in FETCH/MEMRD/MEMWR adds 1 cycle. During the wait, strobes and selects stay constant and `pc_write`/`ir_write`/`retire` stay 0.
- Exactly one `retire` pulse per completed instruction. No retire for illegal opcodes.
- `jr` is sampled only at the EXEC→next edge. It is ignored in every other state.

## Structure
- Shared package `mips_pkg`: opcode constants, state enum (4-bit), `alu_op` codes (ADD/SUB/FUNCT), `alu_src_b` and `pc_source` codes.
- The existing ALU control decoder also consumes the `alu_op` codes from this package.
- One module: a state register plus next-state and output decode.
- No sub-module. The ALU control decoder is instantiated beside this block at datapath top.

## Test plan
- **Reset**: hold `rst_n`=0 mid-MEMWR → `state`=0, `mem_write`=0 immediately (asynchronous). After release, FETCH with `mem_read`=1.
- **LW, `mem_ready`=1**: opcode 100011 → states 0,1,2,3,4; `reg_write`=1 and `mem_to_reg`=1 in cycle 5; `retire` once.
- **R-type `add` then JR**: `jr`=0 → EXEC then RWB with `reg_dst`=1. `jr`=1 → state 12 with `pc_source`=11 and `pc_write`=1; no `reg_write`.
- **ORI**: opcode 001101 → IEXEC/IWB show `alu_op`=10, `alu_inst_sel`=1, `zero_ext`=1; 4 cycles total.
- **Wait states**: `mem_ready` low 3 cycles in FETCH → `ir_write` asserted only in the 4th FETCH cycle; BEQ then totals 6 cycles, with `branch`=1 and `alu_op`=01 in its last cycle.
- **Illegal opcode 111111**: `illegal`=1 for one cycle in DECODE, then FETCH; `retire` never asserted.
